// File: rtl/vga_timing_gen_pkg.sv
// Shared types and VESA presets for the VGA raster timing generator.
package vga_timing_gen_pkg;

    // Encodings are fixed so that state dumps read the same across tools.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        VGA_800X600_60,
        VGA_640X480_60,
        VGA_1024X768_60
    } vga_preset_t;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit h_pol;
        bit v_pol;
    } vga_mode_t;

    // Standard VESA mode timings; 800x600@60 is the fallback.
    function automatic vga_mode_t vga_preset(input vga_preset_t sel);
        vga_mode_t m;
        case (sel)
            VGA_640X480_60:  m = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
            VGA_1024X768_60: m = '{1024, 24, 136, 160, 768, 3, 6, 29, 1'b0, 1'b0};
            default:         m = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
        endcase
        return m;
    endfunction

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam vga_mode_t VGA_DEFAULT = vga_preset(VGA_800X600_60);

endpackage

// File: rtl/vga_axis_cnt.sv
// One raster axis: position counter, terminal flag, registered blank/sync decode.
module vga_axis_cnt #(
    parameter int N_ACTIVE = 800,
    parameter int N_FP     = 40,
    parameter int N_SYNC   = 128,
    parameter int N_BP     = 88,
    parameter bit SYNC_POL = 1'b1,
    parameter int W        = 11
) (
    input  logic         pclk,
    input  logic         rst,
    input  logic         ce,
    input  logic         inc,
    input  logic         idle,
    output logic [W-1:0] count,
    output logic         terminal,
    output logic         blank_nxt,
    output logic         blank,
    output logic         sync
);

    localparam int           N_TOTAL  = N_ACTIVE + N_FP + N_SYNC + N_BP;
    localparam logic [W-1:0] LAST     = W'(N_TOTAL - 1);
    // Thresholds carry one extra bit so a sync window ending exactly at 2^W still compares correctly.
    localparam logic [W:0]   ACT_END  = (W+1)'(N_ACTIVE);
    localparam logic [W:0]   SYNC_BEG = (W+1)'(N_ACTIVE + N_FP);
    localparam logic [W:0]   SYNC_END = (W+1)'(N_ACTIVE + N_FP + N_SYNC);

    logic [W-1:0] count_nxt;
    logic [W:0]   count_ext;
    logic         sync_nxt;

    assign terminal  = (count == LAST);
    assign count_nxt = idle ? '0 : (inc ? (terminal ? '0 : count + 1'b1) : count);
    assign count_ext = {1'b0, count_nxt};

    // Flags are decoded from the next count so they line up with the registered count.
    assign blank_nxt = idle | (count_ext >= ACT_END);
    assign sync_nxt  = ~idle & (count_ext >= SYNC_BEG) & (count_ext < SYNC_END);

    // Counter and flag registers; everything freezes while ce is low.
    always_ff @(posedge pclk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            count <= '0;
            blank <= 1'b1;
            sync  <= ~SYNC_POL;
        end else if (ce) begin
            count <= count_nxt;
            blank <= blank_nxt;
            sync  <= sync_nxt ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA/VESA raster timing generator with pixel enable, run/stop control and frame counting.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CNT_W      = 11,
    parameter int H_ACTIVE   = VGA_DEFAULT.h_active,
    parameter int H_FP       = VGA_DEFAULT.h_fp,
    parameter int H_SYNC     = VGA_DEFAULT.h_sync,
    parameter int H_BP       = VGA_DEFAULT.h_bp,
    parameter int V_ACTIVE   = VGA_DEFAULT.v_active,
    parameter int V_FP       = VGA_DEFAULT.v_fp,
    parameter int V_SYNC     = VGA_DEFAULT.v_sync,
    parameter int V_BP       = VGA_DEFAULT.v_bp,
    parameter bit H_SYNC_POL = VGA_DEFAULT.h_pol,
    parameter bit V_SYNC_POL = VGA_DEFAULT.v_pol,
    parameter int FRAME_W    = 16
) (
    input  logic               pclk,
    input  logic               rst,
    input  logic               ce,
    input  logic               run,
    output logic [CNT_W-1:0]   hcount,
    output logic [CNT_W-1:0]   vcount,
    output logic               hblnk,
    output logic               vblnk,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               busy
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (CNT_W == 0 || FRAME_W == 0) begin : g_bad_width
        $error("vga_timing_gen: CNT_W and FRAME_W must be non-zero");
    end
    if (longint'(H_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (longint'(V_TOTAL) > (64'd1 << CNT_W)) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end

    state_t state;
    logic   active, h_inc, v_inc, h_term, v_term, frame_wrap;
    logic   go_idle, start, h_blank_nxt, v_blank_nxt;

    assign active     = (state != ST_IDLE);
    assign h_inc      = ce & active;
    assign v_inc      = h_inc & h_term;
    assign frame_wrap = active & h_term & v_term;
    // A frame boundary is either leaving IDLE or wrapping the raster; run decides start vs. idle.
    assign go_idle    = ~run & ((state == ST_IDLE) | frame_wrap);
    assign start      =  run & ((state == ST_IDLE) | frame_wrap);

    vga_axis_cnt #(
        .N_ACTIVE (H_ACTIVE), .N_FP (H_FP), .N_SYNC (H_SYNC), .N_BP (H_BP),
        .SYNC_POL (H_SYNC_POL), .W (CNT_W)
    ) u_h_axis (
        .pclk      (pclk),
        .rst       (rst),
        .ce        (ce),
        .inc       (h_inc),
        .idle      (go_idle),
        .count     (hcount),
        .terminal  (h_term),
        .blank_nxt (h_blank_nxt),
        .blank     (hblnk),
        .sync      (hsync)
    );

    vga_axis_cnt #(
        .N_ACTIVE (V_ACTIVE), .N_FP (V_FP), .N_SYNC (V_SYNC), .N_BP (V_BP),
        .SYNC_POL (V_SYNC_POL), .W (CNT_W)
    ) u_v_axis (
        .pclk      (pclk),
        .rst       (rst),
        .ce        (ce),
        .inc       (v_inc),
        .idle      (go_idle),
        .count     (vcount),
        .terminal  (v_term),
        .blank_nxt (v_blank_nxt),
        .blank     (vblnk),
        .sync      (vsync)
    );

    // Run/stop FSM with registered frame_start, frame_cnt, busy and de.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            busy        <= 1'b0;
            de          <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (ce) begin
                case (state)
                    ST_IDLE: if (run) state <= ST_RUN;
                    ST_RUN, ST_STOP: begin
                        if (run)             state <= ST_RUN;
                        else if (frame_wrap) state <= ST_IDLE;
                        else                 state <= ST_STOP;
                    end
                    default: state <= ST_IDLE;
                endcase
                if (start) begin
                    frame_start <= 1'b1;
                    frame_cnt   <= frame_cnt + 1'b1;
                end
                busy <= ~go_idle;
                de   <= ~h_blank_nxt & ~v_blank_nxt;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size 800x600 line timing plus a tiny raster for frame-level behaviour.
module tb_vga_timing_gen;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    int vectors     = 0;
    int miscompares = 0;

    // Default 800x600 instance
    logic        rst_b, ce_b, run_b;
    logic [10:0] hc_b, vc_b;
    logic        hblnk_b, vblnk_b, hsync_b, vsync_b, de_b, fs_b, busy_b;
    logic [15:0] fcnt_b;

    // Small raster: H 8/2/2/4 (16), V 4/1/1/2 (8), active-low syncs, 2-bit frame counter
    logic        rst_s, ce_s, run_s;
    logic [3:0]  hc_s, vc_s;
    logic        hblnk_s, vblnk_s, hsync_s, vsync_s, de_s, fs_s, busy_s;
    logic [1:0]  fcnt_s;

    vga_timing_gen dut_big (
        .pclk (pclk), .rst (rst_b), .ce (ce_b), .run (run_b),
        .hcount (hc_b), .vcount (vc_b), .hblnk (hblnk_b), .vblnk (vblnk_b),
        .hsync (hsync_b), .vsync (vsync_b), .de (de_b),
        .frame_start (fs_b), .frame_cnt (fcnt_b), .busy (busy_b)
    );

    vga_timing_gen #(
        .CNT_W (4), .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (4),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (2),
        .H_SYNC_POL (1'b0), .V_SYNC_POL (1'b0), .FRAME_W (2)
    ) dut_small (
        .pclk (pclk), .rst (rst_s), .ce (ce_s), .run (run_s),
        .hcount (hc_s), .vcount (vc_s), .hblnk (hblnk_s), .vblnk (vblnk_s),
        .hsync (hsync_s), .vsync (vsync_s), .de (de_s),
        .frame_start (fs_s), .frame_cnt (fcnt_s), .busy (busy_s)
    );

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    // {hcount, vcount, hblnk, vblnk, hsync, vsync, de, frame_start, frame_cnt, busy}
    function automatic logic [16:0] snap_s();
        return {hc_s, vc_s, hblnk_s, vblnk_s, hsync_s, vsync_s, de_s, fs_s, fcnt_s, busy_s};
    endfunction

    task automatic restart_small();
        rst_s = 1'b1; run_s = 1'b0; ce_s = 1'b1;
        tick();
        rst_s = 1'b0; run_s = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [16:0] exp_s;
        rst_b = 1'b1; ce_b = 1'b1; run_b = 1'b1;
        rst_s = 1'b1; ce_s = 1'b1; run_s = 1'b1;
        tick(); tick();
        exp_s = {4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vectors++;
        if (snap_s() !== exp_s) begin
            miscompares++;
            $display("FAIL reset_small: got %h expected %h", snap_s(), exp_s);
        end
        vectors++;
        if ({hc_b, vc_b, hblnk_b, vblnk_b, hsync_b, vsync_b, de_b, fs_b, fcnt_b, busy_b} !==
            {11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_big: got hc=%0d vc=%0d hb=%b vb=%b hs=%b vs=%b de=%b fs=%b fc=%0d busy=%b expected idle",
                     hc_b, vc_b, hblnk_b, vblnk_b, hsync_b, vsync_b, de_b, fs_b, fcnt_b, busy_b);
        end
    endtask

    task automatic test_default_line();
        int first_hs = -1, last_hs = -1, hs_cnt = 0, first_hb = -1, bad = 0;
        rst_b = 1'b0; run_b = 1'b1; ce_b = 1'b1;
        tick();
        vectors++;
        if ({fs_b, fcnt_b, busy_b, de_b} !== {1'b1, 16'd1, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL big_start: got fs=%b fc=%0d busy=%b de=%b expected 1 1 1 1", fs_b, fcnt_b, busy_b, de_b);
        end
        for (int k = 0; k < 1056; k++) begin
            if (k > 0) tick();
            if (hc_b !== 11'(k) || vc_b !== 11'd0) bad++;
            if (hsync_b === 1'b1) begin
                if (first_hs < 0) first_hs = k;
                last_hs = k;
                hs_cnt++;
            end
            if (hblnk_b === 1'b1 && first_hb < 0) first_hb = k;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL big_line_pos: got %0d bad positions expected 0", bad);
        end
        vectors++;
        if (first_hs != 840 || last_hs != 967 || hs_cnt != 128) begin
            miscompares++;
            $display("FAIL big_hsync_window: got %0d..%0d (%0d) expected 840..967 (128)", first_hs, last_hs, hs_cnt);
        end
        vectors++;
        if (first_hb != 800) begin
            miscompares++;
            $display("FAIL big_hblnk_rise: got %0d expected 800", first_hb);
        end
        tick();
        vectors++;
        if ({hc_b, vc_b} !== {11'd0, 11'd1}) begin
            miscompares++;
            $display("FAIL big_line_wrap: got (%0d,%0d) expected (0,1)", hc_b, vc_b);
        end
    endtask

    task automatic test_small_frame();
        int bad_pos = 0, hs_bad = 0, vs_bad = 0, de_bad = 0, de_n = 0, fs_n = 0, first_vb = -1;
        int eh, ev;
        restart_small();
        vectors++;
        if ({fs_s, fcnt_s} !== {1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL small_first_start: got fs=%b fc=%0d expected 1 1", fs_s, fcnt_s);
        end
        for (int k = 0; k < 128; k++) begin
            if (k > 0) tick();
            eh = k % 16;
            ev = k / 16;
            if ({hc_s, vc_s} !== {4'(eh), 4'(ev)}) bad_pos++;
            if (hsync_s !== ((eh == 10 || eh == 11) ? 1'b0 : 1'b1)) hs_bad++;
            if (vsync_s !== ((ev == 5) ? 1'b0 : 1'b1)) vs_bad++;
            if (de_s !== ((eh < 8 && ev < 4) ? 1'b1 : 1'b0)) de_bad++;
            if (de_s === 1'b1) de_n++;
            if (k > 0 && fs_s !== 1'b0) fs_n++;
            if (vblnk_s === 1'b1 && first_vb < 0) first_vb = k;
        end
        vectors++;
        if (bad_pos != 0) begin
            miscompares++;
            $display("FAIL small_positions: got %0d bad expected 0", bad_pos);
        end
        vectors++;
        if (hs_bad != 0 || vs_bad != 0) begin
            miscompares++;
            $display("FAIL small_sync: got hs_bad=%0d vs_bad=%0d expected 0 0", hs_bad, vs_bad);
        end
        vectors++;
        if (de_bad != 0 || de_n != 32) begin
            miscompares++;
            $display("FAIL small_de: got bad=%0d count=%0d expected 0 32", de_bad, de_n);
        end
        vectors++;
        if (fs_n != 0 || first_vb != 64) begin
            miscompares++;
            $display("FAIL small_mid_frame: got extra_fs=%0d vblnk_rise=%0d expected 0 64", fs_n, first_vb);
        end
        tick();
        vectors++;
        if ({fs_s, fcnt_s, hc_s, vc_s} !== {1'b1, 2'd2, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL small_second_start: got fs=%b fc=%0d (%0d,%0d) expected 1 2 (0,0)", fs_s, fcnt_s, hc_s, vc_s);
        end
        repeat (128) tick();
        vectors++;
        if ({fs_s, fcnt_s} !== {1'b1, 2'd3}) begin
            miscompares++;
            $display("FAIL small_third_frame: got fs=%b fc=%0d expected 1 3", fs_s, fcnt_s);
        end
        repeat (128) tick();
        vectors++;
        if ({fs_s, fcnt_s} !== {1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL small_fcnt_wrap: got fs=%b fc=%0d expected 1 0", fs_s, fcnt_s);
        end
    endtask

    task automatic test_ce_toggle();
        int bad = 0, fs_early = 0;
        restart_small();
        for (int n = 1; n <= 256; n++) begin
            ce_s = (n % 2 == 0);
            tick();
            if (n < 256) begin
                if ({hc_s, vc_s} !== {4'((n / 2) % 16), 4'((n / 2) / 16)}) bad++;
                if (fs_s !== 1'b0) fs_early++;
            end
        end
        vectors++;
        if (bad != 0 || fs_early != 0) begin
            miscompares++;
            $display("FAIL ce_hold: got bad=%0d early_fs=%0d expected 0 0", bad, fs_early);
        end
        vectors++;
        if ({fs_s, fcnt_s, hc_s, vc_s} !== {1'b1, 2'd2, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL ce_period: got fs=%b fc=%0d (%0d,%0d) expected 1 2 (0,0)", fs_s, fcnt_s, hc_s, vc_s);
        end
        ce_s = 1'b0;
        tick();
        vectors++;
        if ({fs_s, fcnt_s, hc_s, vc_s} !== {1'b0, 2'd2, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL ce_pulse_width: got fs=%b fc=%0d (%0d,%0d) expected 0 2 (0,0)", fs_s, fcnt_s, hc_s, vc_s);
        end
        ce_s = 1'b1;
    endtask

    task automatic test_run_stop();
        logic [16:0] exp_idle;
        restart_small();
        repeat (53) tick();
        vectors++;
        if ({hc_s, vc_s} !== {4'd5, 4'd3}) begin
            miscompares++;
            $display("FAIL stop_setup: got (%0d,%0d) expected (5,3)", hc_s, vc_s);
        end
        run_s = 1'b0;
        repeat (74) tick();
        vectors++;
        if ({hc_s, vc_s, busy_s} !== {4'd15, 4'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL stop_completes: got (%0d,%0d) busy=%b expected (15,7) 1", hc_s, vc_s, busy_s);
        end
        tick();
        exp_idle = {4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
        vectors++;
        if (snap_s() !== exp_idle) begin
            miscompares++;
            $display("FAIL stop_to_idle: got %h expected %h", snap_s(), exp_idle);
        end
        repeat (5) tick();
        vectors++;
        if (snap_s() !== exp_idle) begin
            miscompares++;
            $display("FAIL idle_holds: got %h expected %h", snap_s(), exp_idle);
        end
    endtask

    task automatic test_back_to_back();
        int fs_n = 0;
        run_s = 1'b1;
        tick();
        vectors++;
        if ({fs_s, fcnt_s, hc_s, vc_s, busy_s} !== {1'b1, 2'd2, 4'd0, 4'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL rerun_start: got fs=%b fc=%0d (%0d,%0d) busy=%b expected 1 2 (0,0) 1",
                     fs_s, fcnt_s, hc_s, vc_s, busy_s);
        end
        repeat (53) tick();
        run_s = 1'b0;
        repeat (10) tick();
        vectors++;
        if ({hc_s, vc_s, busy_s} !== {4'd15, 4'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL stop_counting: got (%0d,%0d) busy=%b expected (15,3) 1", hc_s, vc_s, busy_s);
        end
        run_s = 1'b1;
        tick();
        vectors++;
        if ({hc_s, vc_s} !== {4'd0, 4'd4}) begin
            miscompares++;
            $display("FAIL resume_no_gap: got (%0d,%0d) expected (0,4)", hc_s, vc_s);
        end
        repeat (63) begin
            tick();
            if (fs_s !== 1'b0) fs_n++;
        end
        tick();
        vectors++;
        if (fs_n != 0 || {fs_s, fcnt_s} !== {1'b1, 2'd3}) begin
            miscompares++;
            $display("FAIL resume_schedule: got early=%0d fs=%b fc=%0d expected 0 1 3", fs_n, fs_s, fcnt_s);
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] exp_rst;
        restart_small();
        repeat (37) tick();
        vectors++;
        if ({hc_s, vc_s} !== {4'd5, 4'd2}) begin
            miscompares++;
            $display("FAIL rst_mid_setup: got (%0d,%0d) expected (5,2)", hc_s, vc_s);
        end
        rst_s = 1'b1;
        tick();
        exp_rst = {4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vectors++;
        if (snap_s() !== exp_rst) begin
            miscompares++;
            $display("FAIL rst_mid_abort: got %h expected %h", snap_s(), exp_rst);
        end
        rst_s = 1'b0;
        tick();
        vectors++;
        if ({fs_s, fcnt_s, hc_s, vc_s, de_s, busy_s} !== {1'b1, 2'd1, 4'd0, 4'd0, 1'b1, 1'b1}) begin
            miscompares++;
            $display("FAIL rst_restart: got fs=%b fc=%0d (%0d,%0d) de=%b busy=%b expected 1 1 (0,0) 1 1",
                     fs_s, fcnt_s, hc_s, vc_s, de_s, busy_s);
        end
    endtask

    initial begin
        test_reset();
        test_default_line();
        test_small_frame();
        test_ce_toggle();
        test_run_stop();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
